// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and reset constants for the UART receive
// scheduling block (config FSM states, FIFO entry layout, reset config).
package uart_rx_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        APPLY = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic       perr;
        logic [7:0] data;
    } rx_entry_t;

    localparam logic RST_BIT8       = 1'b1;
    localparam logic RST_PARITY_EN  = 1'b0;
    localparam logic RST_ODD_N_EVEN = 1'b0;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO of rx_entry_t.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, push_entry write request and entry
//   pop              read request (ignored when empty)
//   head             head entry (combinational), last popped entry when empty
//   valid            FIFO non-empty
//   drop             push refused because FIFO full and no pop this cycle
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  rx_entry_t push_entry,
    input  logic      pop,
    output rx_entry_t head,
    output logic      valid,
    output logic      drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    rx_entry_t     mem_q [DEPTH];
    rx_entry_t     mem_d [DEPTH];
    rx_entry_t     hold_q, hold_d;
    logic          empty_s, full_s, push_ok_s, pop_ok_s;

    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok_s  = pop && !empty_s;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s = push && (!full_s || pop_ok_s);
    assign drop      = push && full_s && !pop_ok_s;
    assign valid     = !empty_s;
    assign head      = empty_s ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

    // Next-state for pointers, storage and the held output value.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        hold_d   = hold_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            hold_d   = mem_q[rd_ptr_q[AW-1:0]];
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            hold_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            hold_q   <= hold_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_rx_sched.sv
// uart_rx_sched: control/sequencing for the UART receive datapath.
// Generates the 16x baud enable, defers frame configuration changes until
// the receiver is idle, buffers received bytes with parity status, and
// keeps sticky overflow / framing status.
// Optional feature macro: UART_RX_TIMEOUT_EN (idle receive timeout).
// Ports:
//   CLK, RESET_N                  clock, async active-low reset
//   cfg_* / cfg_wr / cfg_busy     host config request and pending flag
//   baud_en, rx_bit8/parity_en/odd_n_even   applied config to receiver
//   rx_idle/data/stb/parity_err/framing_err, rx_clr_err   receiver side
//   rd_en, rd_data, rd_perr, rd_valid   FIFO read port
//   overflow, ferr, stat_clr, timeout   status
module uart_rx_sched
    import uart_rx_pkg::*;
#(
    parameter int unsigned DIV_W         = 13,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned TIMEOUT_CHARS = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DIV_W-1:0] cfg_baud_val,
    input  logic             cfg_bit8,
    input  logic             cfg_parity_en,
    input  logic             cfg_odd_n_even,
    input  logic             cfg_wr,
    output logic             cfg_busy,
    output logic             baud_en,
    output logic             rx_bit8,
    output logic             rx_parity_en,
    output logic             rx_odd_n_even,
    input  logic             rx_idle,
    input  logic [7:0]       rx_data,
    input  logic             rx_stb,
    input  logic             rx_parity_err,
    input  logic             rx_framing_err,
    output logic             rx_clr_err,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_perr,
    output logic             rd_valid,
    output logic             overflow,
    output logic             ferr,
    input  logic             stat_clr,
    output logic             timeout
);

    cfg_state_e       state_q, state_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d;
    logic             sh_bit8_q, sh_bit8_d;
    logic             sh_par_q, sh_par_d;
    logic             sh_odd_q, sh_odd_d;
    logic             cfg_busy_q, cfg_busy_d;
    logic             rx_bit8_q, rx_bit8_d;
    logic             rx_par_q, rx_par_d;
    logic             rx_odd_q, rx_odd_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             baud_en_q, baud_en_d;
    logic             clr_err_q, clr_err_d;
    logic             overflow_q, overflow_d;
    logic             ferr_q, ferr_d;
    logic             apply_s, tick_s, drop_s;
    rx_entry_t        head_s;

    // Config FSM: capture requests into shadow registers, apply when idle.
    always_comb begin
        state_d  = state_q;
        sh_div_d = sh_div_q;
        sh_bit8_d = sh_bit8_q;
        sh_par_d = sh_par_q;
        sh_odd_d = sh_odd_q;
        if (cfg_wr) begin
            sh_div_d  = cfg_baud_val;
            sh_bit8_d = cfg_bit8;
            sh_par_d  = cfg_parity_en;
            sh_odd_d  = cfg_odd_n_even;
        end else begin
            sh_div_d  = sh_div_q;
        end
        case (state_q)
            RUN: begin
                if (cfg_wr) state_d = PEND;
                else        state_d = RUN;
            end
            PEND: begin
                // A byte strobe means the receiver is just leaving a frame.
                if (rx_idle && !rx_stb) state_d = APPLY;
                else                    state_d = PEND;
            end
            APPLY: begin
                // A write landing in the apply cycle is kept for a new round.
                if (cfg_wr) state_d = PEND;
                else        state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign apply_s = (state_q == APPLY);
    // Applying acts like a counter at zero: pulse next cycle, reload new divisor.
    assign tick_s  = apply_s || (cnt_q == '0);

    // Applied config, divisor and baud counter next-state.
    always_comb begin
        cfg_busy_d = (state_d != RUN);
        if (apply_s) begin
            rx_bit8_d = sh_bit8_q;
            rx_par_d  = sh_par_q;
            rx_odd_d  = sh_odd_q;
            div_d     = sh_div_q;
        end else begin
            rx_bit8_d = rx_bit8_q;
            rx_par_d  = rx_par_q;
            rx_odd_d  = rx_odd_q;
            div_d     = div_q;
        end
        baud_en_d = tick_s;
        if (tick_s) cnt_d = div_d;
        else        cnt_d = cnt_q - DIV_W'(1);
    end

    // Status next-state; a set in the same cycle as stat_clr wins.
    always_comb begin
        clr_err_d = rx_stb;
        if (drop_s)        overflow_d = 1'b1;
        else if (stat_clr) overflow_d = 1'b0;
        else               overflow_d = overflow_q;
        if (rx_framing_err) ferr_d = 1'b1;
        else if (stat_clr)  ferr_d = 1'b0;
        else                ferr_d = ferr_q;
    end

    // Control, config and status registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= RUN;
            sh_div_q   <= '0;
            sh_bit8_q  <= RST_BIT8;
            sh_par_q   <= RST_PARITY_EN;
            sh_odd_q   <= RST_ODD_N_EVEN;
            cfg_busy_q <= 1'b0;
            rx_bit8_q  <= RST_BIT8;
            rx_par_q   <= RST_PARITY_EN;
            rx_odd_q   <= RST_ODD_N_EVEN;
            div_q      <= '0;
            cnt_q      <= '0;
            baud_en_q  <= 1'b0;
            clr_err_q  <= 1'b0;
            overflow_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_div_q   <= sh_div_d;
            sh_bit8_q  <= sh_bit8_d;
            sh_par_q   <= sh_par_d;
            sh_odd_q   <= sh_odd_d;
            cfg_busy_q <= cfg_busy_d;
            rx_bit8_q  <= rx_bit8_d;
            rx_par_q   <= rx_par_d;
            rx_odd_q   <= rx_odd_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            baud_en_q  <= baud_en_d;
            clr_err_q  <= clr_err_d;
            overflow_q <= overflow_d;
            ferr_q     <= ferr_d;
        end
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .push       (rx_stb),
        .push_entry ('{perr: rx_parity_err, data: rx_data}),
        .pop        (rd_en),
        .head       (head_s),
        .valid      (rd_valid),
        .drop       (drop_s)
    );

    assign cfg_busy      = cfg_busy_q;
    assign baud_en       = baud_en_q;
    assign rx_bit8       = rx_bit8_q;
    assign rx_parity_en  = rx_par_q;
    assign rx_odd_n_even = rx_odd_q;
    assign rx_clr_err    = clr_err_q;
    assign rd_data       = head_s.data;
    assign rd_perr       = head_s.perr;
    assign overflow      = overflow_q;
    assign ferr          = ferr_q;

`ifdef UART_RX_TIMEOUT_EN
    // One character is 10 bit times of 16 oversample ticks.
    localparam int unsigned TO_TC = 16 * 10 * TIMEOUT_CHARS;
    localparam int unsigned TO_W  = $clog2(TO_TC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            push_ok_s, pop_ok_s, to_hit_s;

    assign pop_ok_s  = rd_en && rd_valid;
    assign push_ok_s = rx_stb && !drop_s;
    assign to_hit_s  = rd_valid && !push_ok_s && !pop_ok_s && baud_en_q &&
                       (to_cnt_q == TO_W'(TO_TC - 1));

    // Idle counter and sticky timeout next-state.
    always_comb begin
        if (push_ok_s || pop_ok_s || !rd_valid)           to_cnt_d = '0;
        else if (baud_en_q && (to_cnt_q != TO_W'(TO_TC))) to_cnt_d = to_cnt_q + TO_W'(1);
        else                                              to_cnt_d = to_cnt_q;
        if (to_hit_s)                  timeout_d = 1'b1;
        else if (pop_ok_s || stat_clr) timeout_d = 1'b0;
        else                           timeout_d = timeout_q;
    end

    // Timeout registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sched.sv
// Directed self-checking bench for uart_rx_sched.
module tb_uart_rx_sched;

    localparam int DIV_W = 13;

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic [DIV_W-1:0] cfg_baud_val;
    logic             cfg_bit8, cfg_parity_en, cfg_odd_n_even, cfg_wr;
    logic             cfg_busy, baud_en, rx_bit8, rx_parity_en, rx_odd_n_even;
    logic             rx_idle, rx_stb, rx_parity_err, rx_framing_err, rx_clr_err;
    logic [7:0]       rx_data, rd_data;
    logic             rd_en, rd_perr, rd_valid, overflow, ferr, stat_clr, timeout;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    uart_rx_sched #(.DIV_W(DIV_W), .FIFO_DEPTH(4), .TIMEOUT_CHARS(1)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .cfg_baud_val   (cfg_baud_val),
        .cfg_bit8       (cfg_bit8),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_odd_n_even (cfg_odd_n_even),
        .cfg_wr         (cfg_wr),
        .cfg_busy       (cfg_busy),
        .baud_en        (baud_en),
        .rx_bit8        (rx_bit8),
        .rx_parity_en   (rx_parity_en),
        .rx_odd_n_even  (rx_odd_n_even),
        .rx_idle        (rx_idle),
        .rx_data        (rx_data),
        .rx_stb         (rx_stb),
        .rx_parity_err  (rx_parity_err),
        .rx_framing_err (rx_framing_err),
        .rx_clr_err     (rx_clr_err),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_perr        (rd_perr),
        .rd_valid       (rd_valid),
        .overflow       (overflow),
        .ferr           (ferr),
        .stat_clr       (stat_clr),
        .timeout        (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        rx_data       = d;
        rx_parity_err = pe;
        rx_stb        = 1'b1;
        tick();
        rx_stb        = 1'b0;
        rx_parity_err = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] d, input logic pe);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_data"}, rd_data, d);
        check({tag, "_perr"}, rd_perr, pe);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_not_busy();
        for (int i = 0; i < 20; i++) begin
            if (!cfg_busy) break;
            tick();
        end
    endtask

    initial begin
        int n;
        RESET_N = 1'b0; cfg_baud_val = '0; cfg_bit8 = 1'b0; cfg_parity_en = 1'b0;
        cfg_odd_n_even = 1'b0; cfg_wr = 1'b0; rx_idle = 1'b1; rx_data = 8'h00;
        rx_stb = 1'b0; rx_parity_err = 1'b0; rx_framing_err = 1'b0;
        rd_en = 1'b0; stat_clr = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_baud_en", baud_en, 1'b0);
        check("rst_cfg_busy", cfg_busy, 1'b0);
        check("rst_clr_err", rx_clr_err, 1'b0);
        check("rst_bit8", rx_bit8, 1'b1);
        check("rst_par", rx_parity_en, 1'b0);
        check("rst_odd", rx_odd_n_even, 1'b0);
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 8'h00);
        check("rst_perr", rd_perr, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        // Divisor 0 after reset: baud_en constantly high
        RESET_N = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("div0_baud", baud_en, 1'b1);
            tick();
        end

        // Baud period with divisor 5
        cfg_baud_val = 13'd5; cfg_bit8 = 1'b1; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("baud_cfg_busy", cfg_busy, 1'b1);
        wait_not_busy();
        check("baud_busy_drop", cfg_busy, 1'b0);
        for (int i = 0; i < 13; i++) begin
            check("baud_p6", baud_en, ((i % 6) == 0) ? 1'b1 : 1'b0);
            tick();
        end

        // Deferred config, last write wins
        rx_idle = 1'b0;
        cfg_baud_val = 13'd0; cfg_bit8 = 1'b0; cfg_parity_en = 1'b0; cfg_odd_n_even = 1'b1;
        cfg_wr = 1'b1;
        tick();
        check("def_busy1", cfg_busy, 1'b1);
        cfg_parity_en = 1'b1; cfg_odd_n_even = 1'b0;
        tick();
        cfg_wr = 1'b0;
        repeat (3) tick();
        check("def_busy_hold", cfg_busy, 1'b1);
        check("def_bit8_old", rx_bit8, 1'b1);
        check("def_par_old", rx_parity_en, 1'b0);
        check("def_odd_old", rx_odd_n_even, 1'b0);
        rx_idle = 1'b1;
        wait_not_busy();
        check("def_busy_drop", cfg_busy, 1'b0);
        check("def_bit8_new", rx_bit8, 1'b0);
        check("def_par_new", rx_parity_en, 1'b1);
        check("def_odd_new", rx_odd_n_even, 1'b0);
        tick();
        check("def_div0_baud", baud_en, 1'b1);

        // FIFO fill and drop
        push(8'h11, 1'b0);
        check("fifo_clr_err", rx_clr_err, 1'b1);
        check("fifo_head1", rd_data, 8'h11);
        tick();
        check("fifo_clr_err_end", rx_clr_err, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        check("fifo_no_ovf", overflow, 1'b0);
        push(8'h55, 1'b0);
        check("fifo_ovf", overflow, 1'b1);
        pop_chk("rd11", 8'h11, 1'b0);
        pop_chk("rd22", 8'h22, 1'b0);
        pop_chk("rd33", 8'h33, 1'b0);
        pop_chk("rd44", 8'h44, 1'b0);
        check("fifo_empty", rd_valid, 1'b0);
        check("fifo_hold", rd_data, 8'h44);

        // Status set / clear
        rx_framing_err = 1'b1; tick(); rx_framing_err = 1'b0;
        check("st_ferr_set", ferr, 1'b1);
        check("st_ovf_kept", overflow, 1'b1);
        rx_framing_err = 1'b1; stat_clr = 1'b1; tick();
        rx_framing_err = 1'b0; stat_clr = 1'b0;
        check("st_ferr_wins", ferr, 1'b1);
        check("st_ovf_clr", overflow, 1'b0);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("st_ferr_clr", ferr, 1'b0);
        check("st_ovf_clr2", overflow, 1'b0);

        // Overflow set beats stat_clr in the same cycle
        push(8'h01, 1'b0);
        push(8'h02, 1'b1);
        check("perr_clr_err", rx_clr_err, 1'b1);
        push(8'h03, 1'b0);
        push(8'h04, 1'b0);
        stat_clr = 1'b1;
        push(8'h99, 1'b0);
        stat_clr = 1'b0;
        check("ovf_set_wins", overflow, 1'b1);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        check("ovf_clr3", overflow, 1'b0);

        // Full FIFO with push and pop together
        check("sim_head01", rd_data, 8'h01);
        rd_en = 1'b1;
        push(8'hA5, 1'b0);
        rd_en = 1'b0;
        check("sim_no_ovf", overflow, 1'b0);
        pop_chk("rd02", 8'h02, 1'b1);
        pop_chk("rd03", 8'h03, 1'b0);
        pop_chk("rd04", 8'h04, 1'b0);
        pop_chk("rdA5", 8'hA5, 1'b0);
        check("sim_empty", rd_valid, 1'b0);

        // Empty FIFO with push and rd_en together: push only
        rd_en = 1'b1;
        push(8'h77, 1'b0);
        rd_en = 1'b0;
        pop_chk("rd77", 8'h77, 1'b0);
        check("e_empty", rd_valid, 1'b0);

        // Idle timeout (divisor 0, one character = 160 baud_en)
        push(8'h5A, 1'b0);
        n = 0;
`ifdef UART_RX_TIMEOUT_EN
        while (!timeout && n < 400) begin
            tick();
            n++;
        end
        check("to_cycles", n, 160);
        check("to_set", timeout, 1'b1);
        pop_chk("rd5A", 8'h5A, 1'b0);
        check("to_clr", timeout, 1'b0);
`else
        while (n < 200) begin
            tick();
            n++;
        end
        check("to_tied0", timeout, 1'b0);
        pop_chk("rd5A", 8'h5A, 1'b0);
`endif

        // Reset mid-stream discards FIFO contents
        push(8'h33, 1'b0);
        check("mid_valid", rd_valid, 1'b1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_valid", rd_valid, 1'b0);
        check("mid_rst_data", rd_data, 8'h00);
        tick();
        RESET_N = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
